pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/bs_pkg.sv | 9 +
 rtl/pipelined_barrel_shifter_if.sv | 29 ++
 rtl/bs_pipe_stage.sv | 62 ++++++
 rtl/pipelined_barrel_shifter.sv | 67 ++++++
 tb/tb_pipelined_barrel_shifter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bs_pkg.sv
// Shared operation encodings for the pipelined barrel shifter and its bench.
package bs_pkg;
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ROR = 2'b00;
   localparam mode_t MODE_ROL = 2'b01;
   localparam mode_t MODE_SRL = 2'b10;
   localparam mode_t MODE_SRA = 2'b11;
endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Stream bundle for the barrel shifter: input beat, output result, busy flag.
interface pipelined_barrel_shifter_if
   import bs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input logic clk
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [AMT_W-1:0] amt;
   mode_t            mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             busy;

   modport master (
      input  clk, in_ready, out_valid, y, busy,
      output in_valid, a, amt, mode, out_ready
   );

   modport slave (
      input  clk, in_valid, a, amt, mode, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/bs_pipe_stage.sv
// One shifter stage: moves data by SHIFT positions when its amt bit is set,
// then registers data, amt, mode and valid together.
module bs_pipe_stage
   import bs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHIFT = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   input  logic [AMT_W-1:0] src_amt,
   input  mode_t            src_mode,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [AMT_W-1:0] amt,
   output mode_t            mode
);
   localparam int BIT = $clog2(SHIFT);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;
   logic [AMT_W-1:0] amt_reg;
   mode_t            mode_reg;
   logic [WIDTH-1:0] data_next;

   // Arithmetic shifts replicate the current MSB; earlier stages never alter
   // it, so it always equals the original operand's sign bit.
   always_comb begin
      data_next = src_data;
      if (src_amt[BIT]) begin
         case (src_mode)
            MODE_ROR: data_next = {src_data[SHIFT-1:0], src_data[WIDTH-1:SHIFT]};
            MODE_ROL: data_next = {src_data[WIDTH-SHIFT-1:0], src_data[WIDTH-1:WIDTH-SHIFT]};
            MODE_SRL: data_next = {{SHIFT{1'b0}}, src_data[WIDTH-1:SHIFT]};
            default:  data_next = {{SHIFT{src_data[WIDTH-1]}}, src_data[WIDTH-1:SHIFT]};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         amt_reg   <= '0;
         mode_reg  <= MODE_ROR;
      end else if (advance) begin
         valid_reg <= src_valid;
         data_reg  <= data_next;
         amt_reg   <= src_amt;
         mode_reg  <= src_mode;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign amt   = amt_reg;
   assign mode  = mode_reg;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Rotate/shift unit split into AMT_W registered stages, stage k handling 2^k,
// with a single global advance so the whole pipe moves or stalls as one.
module pipelined_barrel_shifter
   import bs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  mode_t            mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);
   logic [AMT_W-1:0] st_valid;
   logic [WIDTH-1:0] st_data [AMT_W];
   logic [AMT_W-1:0] st_amt  [AMT_W];
   mode_t            st_mode [AMT_W];
   logic             advance;

   // in_ready depends only on the output side, never on in_valid.
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = st_valid[AMT_W-1];
   assign y         = st_data[AMT_W-1];
   assign busy      = |st_valid;

   generate
      for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            bs_pipe_stage #(.WIDTH(WIDTH), .SHIFT(1)) u_stage (
               .clk       (clk),
               .rst_n     (rst_n),
               .advance   (advance),
               .src_valid (in_valid),
               .src_data  (a),
               .src_amt   (amt),
               .src_mode  (mode),
               .valid     (st_valid[gi]),
               .data      (st_data[gi]),
               .amt       (st_amt[gi]),
               .mode      (st_mode[gi])
            );
         end else begin : g_rest
            bs_pipe_stage #(.WIDTH(WIDTH), .SHIFT(1 << gi)) u_stage (
               .clk       (clk),
               .rst_n     (rst_n),
               .advance   (advance),
               .src_valid (st_valid[gi-1]),
               .src_data  (st_data[gi-1]),
               .src_amt   (st_amt[gi-1]),
               .src_mode  (st_mode[gi-1]),
               .valid     (st_valid[gi]),
               .data      (st_data[gi]),
               .amt       (st_amt[gi]),
               .mode      (st_mode[gi])
            );
         end
      end
   endgenerate
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for the pipelined barrel shifter at WIDTH=8.
module tb_pipelined_barrel_shifter;
   import bs_pkg::*;

   localparam int W  = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_barrel_shifter_if #(.WIDTH(W)) bus (.clk(clk));

   pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .a         (bus.a),
      .amt       (bus.amt),
      .mode      (bus.mode),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .y         (bus.y),
      .busy      (bus.busy)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q [$];

   function automatic logic [W-1:0] ref_model(logic [W-1:0] x, logic [AW-1:0] s, mode_t m);
      logic [2*W-1:0] dbl;
      dbl = {x, x};
      case (m)
         MODE_ROR: begin dbl = dbl >> s; return dbl[W-1:0]; end
         MODE_ROL: begin dbl = dbl << s; return dbl[2*W-1:W]; end
         MODE_SRL: return x >> s;
         default:  return W'($signed(x) >>> s);
      endcase
   endfunction

   task automatic drive(logic v, logic [W-1:0] x, logic [AW-1:0] s, mode_t m, logic ordy);
      bus.in_valid  = v;
      bus.a         = x;
      bus.amt       = s;
      bus.mode      = m;
      bus.out_ready = ordy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 8'hFF, 3'd3, MODE_SRA, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++; if (bus.y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h want=00", bus.y); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      $display("reset: out_valid=%b y=%h busy=%b in_ready=%b", bus.out_valid, bus.y, bus.busy, bus.in_ready);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, '0, '0, MODE_ROR, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic test_modes();
      logic [W-1:0] spec_tbl [4];
      logic [W-1:0] y_obs;
      int lat;
      spec_tbl[0] = 8'b01110101;
      spec_tbl[1] = 8'b01011101;
      spec_tbl[2] = 8'b00010101;
      spec_tbl[3] = 8'b11110101;
      for (int m = 0; m < 4; m++) begin
         drive(1'b1, 8'b10101011, 3'd3, mode_t'(m), 1'b1);
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mode%0d_accept in_ready=%b want=1", m, bus.in_ready); end
         @(posedge clk); #1;
         drive(1'b0, '0, '0, MODE_ROR, 1'b1);
         lat = 0;
         y_obs = 'x;
         for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin lat = c; y_obs = bus.y; end
            @(posedge clk); #1;
         end
         $display("mode=%0d a=ab amt=3 -> y=%b latency=%0d", m, y_obs, lat);
         checks++; if (lat != AW) begin failures++; $display("FAIL mode%0d_latency got=%0d want=%0d", m, lat, AW); end
         checks++; if (y_obs !== spec_tbl[m]) begin failures++; $display("FAIL mode%0d_y got=%b want=%b", m, y_obs, spec_tbl[m]); end
         checks++; if (ref_model(8'b10101011, 3'd3, mode_t'(m)) !== y_obs) begin failures++; $display("FAIL mode%0d_model got=%b want=%b", m, y_obs, ref_model(8'b10101011, 3'd3, mode_t'(m))); end
      end
   endtask

   task automatic test_back_to_back();
      int idx = 0, n = 0, first_cyc = -1, last_cyc = -1;
      logic [W-1:0] first_y = 'x;
      logic [W-1:0] exp_y;
      exp_q.delete();
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (idx < 8) drive(1'b1, 8'b10101011, idx[AW-1:0], MODE_ROR, 1'b1);
         else         drive(1'b0, '0, '0, MODE_ROR, 1'b1);
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL b2b_unexpected got=%h", bus.y);
            end else begin
               exp_y = exp_q.pop_front();
               if (bus.y !== exp_y) begin failures++; $display("FAIL b2b_result%0d got=%b want=%b", n, bus.y, exp_y); end
            end
            $display("b2b result %0d: y=%b cycle=%0d", n, bus.y, cyc);
            if (n == 0) begin first_cyc = cyc; first_y = bus.y; end
            last_cyc = cyc;
            n++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_model(8'b10101011, idx[AW-1:0], MODE_ROR));
            idx++;
         end
         @(posedge clk); #1;
      end
      checks++; if (n != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", n); end
      checks++; if (last_cyc - first_cyc != 7) begin failures++; $display("FAIL b2b_consecutive span=%0d want=7", last_cyc - first_cyc); end
      checks++; if (first_y !== 8'b10101011) begin failures++; $display("FAIL b2b_amt0 got=%b want=10101011", first_y); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
   endtask

   task automatic test_stall();
      logic [W-1:0] av [8];
      logic [W-1:0] exp_y;
      int idx = 0, n = 0, stall_cnt = 0;
      logic ordy;
      exp_q.delete();
      for (int i = 0; i < 8; i++) av[i] = W'($urandom);
      for (int cyc = 0; cyc < 30; cyc++) begin
         ordy = (cyc >= 8);
         if (idx < 8) drive(1'b1, av[idx], idx[AW-1:0], mode_t'(idx % 4), ordy);
         else         drive(1'b0, '0, '0, MODE_ROR, ordy);
         @(negedge clk);
         if (bus.out_valid && !bus.out_ready) begin
            stall_cnt++;
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); end
            checks++; if (exp_q.size() == 0 || bus.y !== exp_q[0]) begin failures++; $display("FAIL stall_y_frozen got=%h want=%h", bus.y, exp_q.size() ? exp_q[0] : 'x); end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL stall_unexpected got=%h", bus.y);
            end else begin
               exp_y = exp_q.pop_front();
               if (bus.y !== exp_y) begin failures++; $display("FAIL stall_result%0d got=%h want=%h", n, bus.y, exp_y); end
            end
            $display("stall result %0d: y=%h", n, bus.y);
            n++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_model(av[idx], idx[AW-1:0], mode_t'(idx % 4)));
            idx++;
         end
         @(posedge clk); #1;
      end
      checks++; if (stall_cnt != 5) begin failures++; $display("FAIL stall_cycles got=%0d want=5", stall_cnt); end
      checks++; if (n != 8) begin failures++; $display("FAIL stall_count got=%0d want=8", n); end
   endtask

   task automatic test_reset_midstream();
      int got = 0, stale = 0;
      logic [W-1:0] exp_y;
      exp_y = ref_model(8'h96, 3'd5, MODE_ROL);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h5A + W'(i), 3'd1, MODE_SRL, 1'b1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      drive(1'b0, '0, '0, MODE_ROR, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 9; c++) begin
         if (c == 0) drive(1'b1, 8'h96, 3'd5, MODE_ROL, 1'b1);
         else        drive(1'b0, '0, '0, MODE_ROR, 1'b1);
         @(negedge clk);
         if (c == 0) begin
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
         end
         if (bus.out_valid) begin
            if (c == AW && bus.y === exp_y) got++;
            else stale++;
            $display("midrst output: cycle=%0d y=%h", c, bus.y);
         end
         @(posedge clk); #1;
      end
      checks++; if (got != 1) begin failures++; $display("FAIL midrst_first_beat got=%0d want=1", got); end
      checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale got=%0d want=0", stale); end
   endtask

   task automatic test_random();
      localparam int N = 10000;
      int sent = 0, recv = 0, cyc = 0;
      logic v;
      logic [W-1:0] x, exp_y;
      logic [AW-1:0] s;
      mode_t m;
      exp_q.delete();
      while (recv < N && cyc < 60000) begin
         v = (sent < N) && ($urandom_range(3) != 0);
         x = W'($urandom);
         s = AW'($urandom);
         m = mode_t'($urandom);
         drive(v, x, s, m, $urandom_range(9) < 7);
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL rand_unexpected got=%h", bus.y);
            end else begin
               exp_y = exp_q.pop_front();
               if (bus.y !== exp_y) begin failures++; $display("FAIL rand_result%0d got=%h want=%h", recv, bus.y, exp_y); end
            end
            recv++;
            if (recv % 1000 == 0) $display("random: %0d results checked", recv);
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_model(x, s, m));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (recv != N) begin failures++; $display("FAIL rand_timeout got=%0d want=%0d", recv, N); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_stall();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
